// File: rtl/minisys_pkg.sv
//------------------------------------------------------------------------------
// minisys_pkg
// Shared declarations for MiniSys-1A peripherals.
//   uart_rx_state_t : receive deframer states
//   UART_OVS        : oversample ticks per bit
//   UART_DATA_BITS  : data bits per character
//   uart_div()      : clocks per oversample tick for a given clock/baud
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package minisys_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } uart_rx_state_t;

   localparam int UART_OVS       = 16;
   localparam int UART_DATA_BITS = 8;

   // Truncating divide: the residual rate error is absorbed by mid-bit sampling.
   function automatic int uart_div(input int clk_freq, input int baud,
                                   input int ovs = UART_OVS);
      return clk_freq / (baud * ovs);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
//------------------------------------------------------------------------------
// sync_fifo
// First-word-fall-through FIFO: the head entry is always visible on rd_data.
//   clk, rst        : clock, asynchronous active-low reset
//   push, wr_data   : write request and data (dropped when full unless pop)
//   pop             : consume head entry (ignored when empty)
//   rd_data         : head entry, all zeros when empty
//   full, empty     : occupancy flags
//   count           : entries held, 0..DEPTH
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             push_ok;
   logic             pop_ok;

   assign full  = (count_reg == CW'(DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;

   // A pop frees the slot in the same cycle, so a push into a full FIFO
   // still succeeds when accompanied by a pop.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   assign rd_data = empty ? '0 : mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
//------------------------------------------------------------------------------
// uart_rx_ctrl
// 8N1 UART receiver with 16x oversampling, FWFT receive FIFO, sticky errors.
//   clk, rst   : system clock, asynchronous active-low reset
//   uart_rx    : serial input, idle high, asynchronous to clk
//   rx_data    : FIFO head byte (0 when empty)
//   rx_ready   : FIFO not empty
//   rx_pop     : one-cycle strobe consuming the head byte
//   rx_count   : bytes held in the FIFO
//   frame_err  : sticky, stop bit sampled low
//   overrun    : sticky, byte arrived with FIFO full and no pop
//   err_clr    : clears both sticky flags (a simultaneous set wins)
//   rx_int     : rx_ready | frame_err | overrun
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx_ctrl
   import minisys_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 115_200,
   parameter int OVS        = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          uart_rx,
   output logic [7:0]                    rx_data,
   output logic                          rx_ready,
   input  logic                          rx_pop,
   output logic [$clog2(FIFO_DEPTH):0]   rx_count,
   output logic                          frame_err,
   output logic                          overrun,
   input  logic                          err_clr,
   output logic                          rx_int
);

   localparam int DIV = uart_div(CLK_FREQ, BAUD, OVS);
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic                      rx_meta_reg;
   logic                      rxs_reg;
   logic                      rxs_prev_reg;
   logic [TW-1:0]             tick_cnt_reg;
   logic                      tick;
   logic [3:0]                ovs_cnt_reg;
   logic [2:0]                bit_idx_reg;
   logic [UART_DATA_BITS-1:0] shift_reg;
   uart_rx_state_t            state_reg;
   uart_rx_state_t            state_next;
   logic                      frame_err_reg;
   logic                      overrun_reg;

   logic mid_start;
   logic mid_bit;
   logic start_det;
   logic start_ok;
   logic sample_bit;
   logic fifo_push;
   logic frame_set;
   logic fifo_full;
   logic fifo_empty;

   // Synchronizer and edge history preset high so reset release never
   // looks like a start edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_reg  <= 1'b1;
         rxs_reg      <= 1'b1;
         rxs_prev_reg <= 1'b1;
      end else begin
         rx_meta_reg  <= uart_rx;
         rxs_reg      <= rx_meta_reg;
         rxs_prev_reg <= rxs_reg;
      end
   end

   assign tick      = (tick_cnt_reg == TW'(DIV - 1));
   assign mid_start = tick & (ovs_cnt_reg == 4'd7);
   assign mid_bit   = tick & (ovs_cnt_reg == 4'd15);

   // Tick phase restarts on the start edge so every sample lands mid-bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt_reg <= '0;
      end else if (start_det || tick) begin
         tick_cnt_reg <= '0;
      end else begin
         tick_cnt_reg <= tick_cnt_reg + TW'(1);
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:      if (rxs_prev_reg && !rxs_reg) state_next = START;
         START:     if (mid_start) state_next = rxs_reg ? IDLE : DATA;
         DATA:      if (mid_bit && bit_idx_reg == 3'd7) state_next = STOP;
         STOP:      if (mid_bit) state_next = rxs_reg ? IDLE : WAIT_HIGH;
         WAIT_HIGH: if (rxs_reg) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      start_det  = 1'b0;
      start_ok   = 1'b0;
      sample_bit = 1'b0;
      fifo_push  = 1'b0;
      frame_set  = 1'b0;
      case (state_reg)
         IDLE:    start_det  = rxs_prev_reg & ~rxs_reg;
         START:   start_ok   = mid_start & ~rxs_reg;
         DATA:    sample_bit = mid_bit;
         STOP: begin
            fifo_push = mid_bit & rxs_reg;
            frame_set = mid_bit & ~rxs_reg;
         end
         default: ;
      endcase
   end

   // Oversample counter, bit index and LSB-first shift register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovs_cnt_reg <= '0;
         bit_idx_reg <= '0;
         shift_reg   <= '0;
      end else begin
         if (start_det || start_ok) begin
            ovs_cnt_reg <= '0;
            bit_idx_reg <= '0;
         end else begin
            if (tick)       ovs_cnt_reg <= ovs_cnt_reg + 4'd1;
            if (sample_bit) bit_idx_reg <= bit_idx_reg + 3'd1;
         end
         if (sample_bit) shift_reg <= {rxs_reg, shift_reg[UART_DATA_BITS-1:1]};
      end
   end

   // Sticky error flags; a set event in the same cycle as err_clr wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_err_reg <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         if (frame_set)    frame_err_reg <= 1'b1;
         else if (err_clr) frame_err_reg <= 1'b0;
         if (fifo_push && fifo_full && !rx_pop) overrun_reg <= 1'b1;
         else if (err_clr)                      overrun_reg <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (fifo_push),
      .wr_data (shift_reg),
      .pop     (rx_pop),
      .rd_data (rx_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (rx_count)
   );

   assign rx_ready  = ~fifo_empty;
   assign frame_err = frame_err_reg;
   assign overrun   = overrun_reg;
   assign rx_int    = rx_ready | frame_err_reg | overrun_reg;

endmodule
